tag_bit_source: RTL and testbench
=================================

# tag_bit_source

Parametrised backscatter tag bit generator; next generation of the fixed 8-bit rotating pattern source. While `trigger` is high it emits one data bit every `SYMBOL_CYCLES` clocks on `output_data`. The bit can come from a fixed pattern, a host-loaded payload word or a PRBS7 sequence. It supports a bounded frame length with a done pulse, and sits between the tag controller (which drives `trigger`) and the backscatter modulator.

## Interface
- `SYMBOL_CYCLES`, 800: clocks per emitted bit; must be ≥2.
- `PATTERN_WIDTH`, 8: width of the pattern and payload shift registers.
- `PATTERN_INIT`, 8'hAA: fixed pattern (`PATTERN_WIDTH` bits), also the payload register reset value.
- `FRAME_BITS`, 0: bits per frame; 0 = unbounded stream.
- `clock` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-low reset.
- `trigger` in 1: level enable; low aborts and returns to IDLE.
- `mode` in 2: 00 fixed pattern, 01 PRBS7, 10 loaded payload, 11 treated as 00. Latched on frame start.
- `load_en` in 1: payload write strobe.
- `load_data` in `PATTERN_WIDTH`: payload word.
- `output_data` out 1: current bit, registered.
- `bit_strobe` out 1: 1-cycle pulse on the edge `output_data` takes a new bit.
- `frame_done` out 1: 1-cycle pulse when a bounded frame completes.

## Operation
- Reset values:
  - `output_data`, `bit_strobe`, `frame_done` = 0.
  - `state` = IDLE; symbol counter = 0; bit index = 0.
  - Pattern shifter and payload register = `PATTERN_INIT`.
  - LFSR = 7'h7F; latched mode = 00.
- States: IDLE, RUN, DONE.
- IDLE:
  - Any edge with `trigger`=0: outputs 0, counter 0, shifters reloaded.
  - `load_en`=1 with `trigger`=0 writes `load_data` to the payload register.
  - IDLE→RUN: edge with `trigger`=1. Latch `mode`, emit bit 0, `bit_strobe`=1, counter←1, bit index←1.
- RUN:
  - Counter increments each edge and wraps from `SYMBOL_CYCLES`-1 to 0.
  - On each edge where counter==0, emit the next bit, pulse `bit_strobe` and increment bit index.
- Bit sources, MSB first:
  - Pattern (mode 00) and payload (mode 10): shift register rotates left; emitted bit = old MSB.
  - PRBS7 (mode 01): x^7+x^6+1. Emitted bit = lfsr[6]; next lfsr = {lfsr[5:0], lfsr[6]^lfsr[5]}. From seed 7'h7F the first 8 bits are 1,1,1,1,1,1,1,0.
- Frame end (`FRAME_BITS`≠0): at the counter==0 edge where bit index==`FRAME_BITS`:
  - No bit is emitted.
  - `frame_done`=1 for one cycle, `output_data`←0, RUN→DONE.
- DONE: outputs 0 and strobes 0; waits for `trigger` low.
- Any state, edge with `trigger`=0 → IDLE:
  - `output_data`←0; counter and bit index cleared.
  - Pattern shifter ← `PATTERN_INIT`; payload shifter ← payload register; LFSR ← 7'h7F.
  - `frame_done` is not asserted.
- `load_en` while `trigger`=1 (any state, including IDLE on the start edge) is ignored.
- `mode` changes while RUN/DONE are ignored until the next frame.
- Counter width is $clog2(`SYMBOL_CYCLES`). Bit index width is $clog2(`FRAME_BITS`+1), minimum 1.

## Timing
- Latency from `trigger` high to first bit: 1 edge. The first sampled-high edge updates `output_data`.
- Bit n appears on the edge n×`SYMBOL_CYCLES` after the first bit edge; each bit is held exactly `SYMBOL_CYCLES` clocks.
- `frame_done` occurs `FRAME_BITS`×`SYMBOL_CYCLES` clocks after the first bit edge.
- Abort takes 1 edge. Re-raising `trigger` restarts from bit 0 of the reloaded source.
- Asynchronous reset mid-frame forces the reset values immediately.

## Configuration
- `TAG_BIT_SOURCE_PRBS_EN` defined: LFSR and mode 01 present, as above.
- `TAG_BIT_SOURCE_PRBS_EN` undefined: no LFSR logic; mode 01 behaves exactly as mode 00.

## Test plan
- Reset, `SYMBOL_CYCLES`=4, mode 00, `trigger` high at edge 0:
  - `output_data` = 1,0,1,0,1,0,1,0 (repeating), each held 4 clocks.
  - `bit_strobe` pulses at edges 0,4,8,…
- Mode 01 (PRBS enabled): first 8 bits 1,1,1,1,1,1,1,0. With the macro undefined, the same stimulus gives 1,0,1,0,1,0,1,0.
- Load 8'hC3 in IDLE, mode 10, trigger: bits 1,1,0,0,0,0,1,1. A `load_en` with 8'hFF while running leaves the sequence unchanged.
- `FRAME_BITS`=8, `SYMBOL_CYCLES`=4:
  - `frame_done` pulses once at edge 32; `output_data`=0 thereafter; no further strobes while `trigger` is held high.
- `trigger` dropped at edge 9 mid-frame:
  - Edge 10: `output_data`=0, no `frame_done`.
  - `trigger` re-raised: sequence restarts at bit 0 (1 for mode 00).
- Async `reset` low mid-RUN:
  - Outputs 0 immediately.
  - After release with `trigger` high, first bit at the first edge, from `PATTERN_INIT`.

Source files
------------

// File: rtl/tag_bit_source.sv
// Backscatter tag bit generator: fixed pattern, loaded payload or PRBS7, one bit per SYMBOL_CYCLES clocks.
// Define TAG_BIT_SOURCE_PRBS_EN to build the PRBS7 source (mode 01); otherwise mode 01 acts as mode 00.
module tag_bit_source #(
  parameter int                         SYMBOL_CYCLES = 800,
  parameter int                         PATTERN_WIDTH = 8,
  parameter logic [PATTERN_WIDTH-1:0]   PATTERN_INIT  = 8'hAA,
  parameter int                         FRAME_BITS    = 0
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     trigger,
  input  logic [1:0]               mode,
  input  logic                     load_en,
  input  logic [PATTERN_WIDTH-1:0] load_data,
  output logic                     output_data,
  output logic                     bit_strobe,
  output logic                     frame_done
);
  localparam int CW = (SYMBOL_CYCLES > 1) ? $clog2(SYMBOL_CYCLES) : 1;
  localparam int IW = (FRAME_BITS > 0) ? $clog2(FRAME_BITS + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SYMBOL_CYCLES - 1);
  localparam logic [IW-1:0] IDX_END  = IW'(FRAME_BITS);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                   state, state_n;
  logic [CW-1:0]            cnt, cnt_n;
  logic [IW-1:0]            idx, idx_n;
  logic [PATTERN_WIDTH-1:0] pat, pat_n, pay, pay_n, pay_sh, pay_sh_n;
  logic [1:0]               mode_q, mode_n, sel;
  logic                     out_n, stb_n, done_n, advance, src_bit, use_pay, use_prbs;
`ifdef TAG_BIT_SOURCE_PRBS_EN
  logic [6:0]               lfsr, lfsr_n;
`endif

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    idx_n    = idx;
    pat_n    = pat;
    pay_n    = pay;
    pay_sh_n = pay_sh;
    mode_n   = mode_q;
    out_n    = output_data;
    stb_n    = 1'b0;
    done_n   = 1'b0;
    advance  = 1'b0;
    // The start edge must already use the incoming mode, before it is latched.
    sel      = (state == IDLE) ? mode : mode_q;
    use_pay  = (sel == 2'b10);
`ifdef TAG_BIT_SOURCE_PRBS_EN
    lfsr_n   = lfsr;
    use_prbs = (sel == 2'b01);
    src_bit  = use_prbs ? lfsr[6] : use_pay ? pay_sh[PATTERN_WIDTH-1] : pat[PATTERN_WIDTH-1];
`else
    use_prbs = 1'b0;
    src_bit  = use_pay ? pay_sh[PATTERN_WIDTH-1] : pat[PATTERN_WIDTH-1];
`endif

    if (!trigger) begin
      state_n  = IDLE;
      cnt_n    = '0;
      idx_n    = '0;
      out_n    = 1'b0;
      pat_n    = PATTERN_INIT;
      if (load_en) pay_n = load_data;
      pay_sh_n = pay_n;
`ifdef TAG_BIT_SOURCE_PRBS_EN
      lfsr_n   = 7'h7F;
`endif
    end else begin
      case (state)
        IDLE: begin
          state_n = RUN;
          mode_n  = mode;
          advance = 1'b1;
          cnt_n   = CW'(1);
          idx_n   = IW'(1);
        end
        RUN: begin
          cnt_n = (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
          if (cnt == '0) begin
            if (FRAME_BITS != 0 && idx == IDX_END) begin
              done_n  = 1'b1;
              out_n   = 1'b0;
              cnt_n   = '0;
              state_n = DONE;
            end else begin
              advance = 1'b1;
              idx_n   = idx + 1'b1;
            end
          end
        end
        default: out_n = 1'b0;
      endcase
    end

    if (advance) begin
      out_n = src_bit;
      stb_n = 1'b1;
      if (use_pay)
        pay_sh_n = (pay_sh << 1) | (pay_sh >> (PATTERN_WIDTH - 1));
      else if (!use_prbs)
        pat_n = (pat << 1) | (pat >> (PATTERN_WIDTH - 1));
`ifdef TAG_BIT_SOURCE_PRBS_EN
      if (use_prbs) lfsr_n = {lfsr[5:0], lfsr[6] ^ lfsr[5]};
`endif
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      cnt         <= '0;
      idx         <= '0;
      pat         <= PATTERN_INIT;
      pay         <= PATTERN_INIT;
      pay_sh      <= PATTERN_INIT;
      mode_q      <= 2'b00;
      output_data <= 1'b0;
      bit_strobe  <= 1'b0;
      frame_done  <= 1'b0;
`ifdef TAG_BIT_SOURCE_PRBS_EN
      lfsr        <= 7'h7F;
`endif
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      idx         <= idx_n;
      pat         <= pat_n;
      pay         <= pay_n;
      pay_sh      <= pay_sh_n;
      mode_q      <= mode_n;
      output_data <= out_n;
      bit_strobe  <= stb_n;
      frame_done  <= done_n;
`ifdef TAG_BIT_SOURCE_PRBS_EN
      lfsr        <= lfsr_n;
`endif
    end
  end
endmodule

// File: tb/tb_tag_bit_source.sv
// Bench for tag_bit_source: an unbounded and an 8-bit-frame instance share stimulus and are
// checked every cycle against a frame-time model, plus literal sequence and timing checks.
module tb_tag_bit_source;
  localparam int S  = 4;
  localparam int FB = 8;

  logic       clock = 0, reset = 0, trigger = 0, load_en = 0;
  logic [1:0] mode = 0;
  logic [7:0] load_data = 0;
  logic       out_a, stb_a, done_a, out_b, stb_b, done_b;
  int         checks = 0, failures = 0;

  always #5 clock = ~clock;

  tag_bit_source #(.SYMBOL_CYCLES(S), .PATTERN_WIDTH(8), .PATTERN_INIT(8'hAA), .FRAME_BITS(0)) dut_a (
    .clock(clock), .reset(reset), .trigger(trigger), .mode(mode), .load_en(load_en),
    .load_data(load_data), .output_data(out_a), .bit_strobe(stb_a), .frame_done(done_a));

  tag_bit_source #(.SYMBOL_CYCLES(S), .PATTERN_WIDTH(8), .PATTERN_INIT(8'hAA), .FRAME_BITS(FB)) dut_b (
    .clock(clock), .reset(reset), .trigger(trigger), .mode(mode), .load_en(load_en),
    .load_data(load_data), .output_data(out_b), .bit_strobe(stb_b), .frame_done(done_b));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: frame time t counts edges since the start edge; bit k of the frame is bitv(k).
  bit         prbs [127];
  logic [7:0] pinit = 8'hAA;
  bit         act = 0;
  int         t = 0;
  logic [1:0] m = 0;
  logic [7:0] psnap = 8'hAA, preg = 8'hAA;

  initial begin
    logic [6:0] l;
    l = 7'h7F;
    for (int i = 0; i < 127; i++) begin
      prbs[i] = l[6];
      l = {l[5:0], l[6] ^ l[5]};
    end
  end

  function automatic logic bitv(input int k);
    logic [7:0] w;
    w = (m == 2'b10) ? psnap : pinit;
`ifdef TAG_BIT_SOURCE_PRBS_EN
    if (m == 2'b01) return prbs[k % 127];
`endif
    return w[7 - (k % 8)];
  endfunction

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      act = 0; t = 0; preg = 8'hAA; m = 0;
    end else if (!trigger) begin
      act = 0; t = 0;
      if (load_en) preg = load_data;
    end else if (!act) begin
      act = 1; t = 0; m = mode; psnap = preg;
    end else begin
      t++;
    end
  end

  always @(negedge clock) begin
    logic eo, es, eob, esb, edb;
    eo = 0; es = 0; eob = 0; esb = 0; edb = 0;
    if (act) begin
      eo = bitv(t / S);
      es = (t % S == 0);
      if (t < FB * S) begin eob = eo; esb = es; end
      else if (t == FB * S) edb = 1;
    end
    chk("out_a", out_a, eo);
    chk("strobe_a", stb_a, es);
    chk("done_a", done_a, 0);
    chk("out_b", out_b, eob);
    chk("strobe_b", stb_b, esb);
    chk("done_b", done_b, edb);
  end

  // Runs n cycles after the start edge, gathering the first 8 bits of dut_a and the done edge of dut_b.
  task automatic collect(input int n, input bit poke, output logic [7:0] got, output int de);
    int cnt;
    got = 0; cnt = 0; de = -1;
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      if (stb_a && cnt < 8) begin got = {got[6:0], out_a}; cnt++; end
      if (done_b && de < 0) de = i;
      if (poke && i == 5) begin load_en = 1; load_data = 8'hFF; end
      if (poke && i == 6) load_en = 0;
    end
    chk("collect_count", cnt, 8);
  endtask

  task automatic idle(input int n);
    trigger = 0;
    repeat (n) @(negedge clock);
  endtask

  initial begin
    logic [7:0] got;
    int de, w;
    #12;
    chk("rst_out", out_a, 0);
    chk("rst_strobe", stb_a, 0);
    chk("rst_done", done_b, 0);
    @(negedge clock); reset = 1;

    // Fixed pattern, frame end on the bounded instance
    mode = 2'b00; trigger = 1;
    collect(48, 0, got, de);
    chk("pattern_bits", got, 8'hAA);
    chk("frame_done_edge", de, 32);

    // PRBS7 (or pattern when the PRBS source is not built)
    idle(2); mode = 2'b01; trigger = 1;
    collect(36, 0, got, de);
`ifdef TAG_BIT_SOURCE_PRBS_EN
    chk("prbs_bits", got, 8'hFE);
`else
    chk("prbs_off_bits", got, 8'hAA);
`endif

    // Loaded payload, with a load attempt while running
    idle(1); load_en = 1; load_data = 8'hC3;
    @(negedge clock); load_en = 0;
    idle(2); mode = 2'b10; trigger = 1;
    collect(36, 1, got, de);
    chk("payload_bits", got, 8'hC3);

    // Abort mid-frame and restart
    idle(2); mode = 2'b00; trigger = 1;
    repeat (9) @(negedge clock);
    trigger = 0;
    @(negedge clock);
    chk("abort_out_a", out_a, 0);
    chk("abort_out_b", out_b, 0);
    chk("abort_no_done", done_b, 0);
    trigger = 1;
    @(negedge clock);
    chk("restart_bit0", out_a, 1);
    chk("restart_strobe", stb_a, 1);

    // Asynchronous reset while a 1 is being emitted
    w = 0;
    while (out_a !== 1'b1 && w < 20) begin @(negedge clock); w++; end
    chk("reset_wait", (w < 20), 1);
    #2 reset = 0;
    #1;
    chk("async_rst_out_a", out_a, 0);
    chk("async_rst_out_b", out_b, 0);
    @(negedge clock); reset = 1;
    @(negedge clock);
    chk("post_rst_bit0", out_a, 1);
    chk("post_rst_strobe", stb_a, 1);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      @(negedge clock);
      if (trigger) trigger = ($urandom_range(0, 99) >= 2);
      else trigger = ($urandom_range(0, 99) < 30);
      mode      = 2'($urandom_range(0, 3));
      load_en   = ($urandom_range(0, 3) == 0);
      load_data = 8'($urandom);
    end

    @(negedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
